// File: rtl/biriscv_tb_harness_if.sv
// Fetch bus between the biRISC-V core fetch port and the simulation ROM.
// master = core side (issues requests), slave = ROM side (returns responses).
interface biriscv_tb_harness_if;
   logic        fetch_rd;
   logic [31:0] fetch_pc;
   logic        fetch_accept;
   logic        fetch_valid;
   logic [63:0] fetch_instr;
   logic        fetch_error;

   modport master (
      output fetch_rd, fetch_pc,
      input  fetch_accept, fetch_valid, fetch_instr, fetch_error
   );

   modport slave (
      input  fetch_rd, fetch_pc,
      output fetch_accept, fetch_valid, fetch_instr, fetch_error
   );
endinterface

// File: rtl/biriscv_tb_harness.sv
// Simulation support for the dual-issue biRISC-V top: 64-bit instruction ROM,
// free-running cycle counter and periodic progress snapshots of both execute PCs.
module biriscv_tb_harness #(
   parameter int unsigned ROM_AW            = 14,
   parameter int unsigned PROGRESS_INTERVAL = 100000,
   parameter int unsigned CYCLE_W           = 64
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   biriscv_tb_harness_if.slave fetch,
   input  logic                load_we_i,
   input  logic [ROM_AW-1:0]   load_addr_i,
   input  logic [63:0]         load_data_i,
   input  logic [31:0]         pc0_i,
   input  logic [31:0]         pc1_i,
   output logic [CYCLE_W-1:0]  cycle_count_o,
   output logic                progress_o,
   output logic [CYCLE_W-1:0]  progress_cycle_o,
   output logic [31:0]         progress_pc0_o,
   output logic [31:0]         progress_pc1_o
);
   localparam int unsigned DN_W = (PROGRESS_INTERVAL > 1) ? $clog2(PROGRESS_INTERVAL) : 1;
   localparam logic [DN_W-1:0] DN_RELOAD = DN_W'(PROGRESS_INTERVAL - 1);

   logic [63:0]        rom_mem [2**ROM_AW];

   logic               valid_q, valid_d;
   logic               error_q, error_d;
   logic [63:0]        instr_q, instr_d;
   logic [CYCLE_W-1:0] cycle_q, cycle_d;
   logic [DN_W-1:0]    dn_q, dn_d;
   logic [CYCLE_W-1:0] snap_cycle_q, snap_cycle_d;
   logic [31:0]        snap_pc0_q, snap_pc0_d;
   logic [31:0]        snap_pc1_q, snap_pc1_d;

   logic [ROM_AW-1:0]  word_idx;
   logic               fault;
   logic               progress;

   // No reset on the array: contents survive reset and may be loaded by the simulator.
   always_ff @(posedge clk_i) begin
      if (load_we_i) rom_mem[load_addr_i] <= load_data_i;
   end

   always_comb begin
      word_idx     = fetch.fetch_pc[ROM_AW+2:3];
      fault        = (fetch.fetch_pc[2:0] != '0) || (fetch.fetch_pc[31:ROM_AW+3] != '0);
      valid_d      = fetch.fetch_rd;
      error_d      = fetch.fetch_rd && fault;
      instr_d      = (fetch.fetch_rd && !fault) ? rom_mem[word_idx] : '0;

      cycle_d      = cycle_q + CYCLE_W'(1);
      progress     = (dn_q == '0);
      dn_d         = progress ? DN_RELOAD : dn_q - DN_W'(1);

      snap_cycle_d = snap_cycle_q;
      snap_pc0_d   = snap_pc0_q;
      snap_pc1_d   = snap_pc1_q;
      if (progress) begin
         snap_cycle_d = cycle_q;
         snap_pc0_d   = pc0_i;
         snap_pc1_d   = pc1_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q      <= 1'b0;
         error_q      <= 1'b0;
         instr_q      <= '0;
         cycle_q      <= '0;
         dn_q         <= '0;
         snap_cycle_q <= '0;
         snap_pc0_q   <= '0;
         snap_pc1_q   <= '0;
      end else begin
         valid_q      <= valid_d;
         error_q      <= error_d;
         instr_q      <= instr_d;
         cycle_q      <= cycle_d;
         dn_q         <= dn_d;
         snap_cycle_q <= snap_cycle_d;
         snap_pc0_q   <= snap_pc0_d;
         snap_pc1_q   <= snap_pc1_d;
      end
   end

   assign fetch.fetch_accept = rst_ni;
   assign fetch.fetch_valid  = valid_q;
   assign fetch.fetch_error  = error_q;
   assign fetch.fetch_instr  = instr_q;

   assign cycle_count_o      = cycle_q;
   assign progress_o         = progress;
   assign progress_cycle_o   = snap_cycle_q;
   assign progress_pc0_o     = snap_pc0_q;
   assign progress_pc1_o     = snap_pc1_q;
endmodule

// File: tb/tb_biriscv_tb_harness.sv
// Directed bench for biriscv_tb_harness: ROM fetch/fault, preload ordering,
// cycle counter, progress pulses/snapshots and mid-operation reset.
module tb_biriscv_tb_harness;
   localparam int unsigned ROM_AW  = 14;
   localparam int unsigned CYCLE_W = 64;

   logic               clk;
   logic               rst_n;
   logic               load_we;
   logic [ROM_AW-1:0]  load_addr;
   logic [63:0]        load_data;
   logic [31:0]        pc0, pc1;
   logic [CYCLE_W-1:0] cycle_count;
   logic               progress;
   logic [CYCLE_W-1:0] progress_cycle;
   logic [31:0]        progress_pc0, progress_pc1;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned n_fail   = 0;

   localparam logic [63:0] W0_DATA  = 64'h00000013_00000093;
   localparam logic [63:0] W3_OLD   = 64'hDEADBEEF_CAFEF00D;
   localparam logic [63:0] W3_NEW   = 64'h12345678_9ABCDEF0;

   biriscv_tb_harness_if fbus ();

   biriscv_tb_harness #(
      .ROM_AW           (ROM_AW),
      .PROGRESS_INTERVAL(4),
      .CYCLE_W          (CYCLE_W)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .fetch           (fbus),
      .load_we_i       (load_we),
      .load_addr_i     (load_addr),
      .load_data_i     (load_data),
      .pc0_i           (pc0),
      .pc1_i           (pc1),
      .cycle_count_o   (cycle_count),
      .progress_o      (progress),
      .progress_cycle_o(progress_cycle),
      .progress_pc0_o  (progress_pc0),
      .progress_pc1_o  (progress_pc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fetch_req(input logic rd, input logic [31:0] pc);
      fbus.fetch_rd = rd;
      fbus.fetch_pc = pc;
   endtask

   initial begin
      rst_n     = 1'b0;
      load_we   = 1'b0;
      load_addr = '0;
      load_data = '0;
      pc0       = 32'h0000_0011;
      pc1       = 32'h0000_0022;
      fetch_req(1'b0, 32'h0);

      // Held in reset across several edges.
      repeat (3) @(negedge clk);
      check("rst_count",    cycle_count, 64'd0);
      check("rst_progress", {63'd0, progress}, 64'd1);
      check("rst_valid",    {63'd0, fbus.fetch_valid}, 64'd0);
      check("rst_error",    {63'd0, fbus.fetch_error}, 64'd0);
      check("rst_instr",    fbus.fetch_instr, 64'd0);
      check("rst_snap",     progress_cycle, 64'd0);
      check("rst_accept",   {63'd0, fbus.fetch_accept}, 64'd0);

      rst_n = 1'b1;
      // count 0: preload word 0
      #1;
      check("c0_count",    cycle_count, 64'd0);
      check("c0_progress", {63'd0, progress}, 64'd1);
      check("c0_accept",   {63'd0, fbus.fetch_accept}, 64'd1);
      load_we = 1'b1; load_addr = 14'd0; load_data = W0_DATA;

      // count 1: preload word 3 (old value), fetch pc 0x0
      @(negedge clk);
      check("c1_count",    cycle_count, 64'd1);
      check("c1_progress", {63'd0, progress}, 64'd0);
      check("c1_snap_cyc", progress_cycle, 64'd0);
      check("c1_snap_pc0", {32'd0, progress_pc0}, 64'h11);
      check("c1_snap_pc1", {32'd0, progress_pc1}, 64'h22);
      check("c1_valid",    {63'd0, fbus.fetch_valid}, 64'd0);
      load_addr = 14'd3; load_data = W3_OLD;
      fetch_req(1'b1, 32'h0000_0000);

      // count 2: word 0 response; fetch misaligned pc 0x4
      @(negedge clk);
      check("c2_count",  cycle_count, 64'd2);
      check("c2_valid",  {63'd0, fbus.fetch_valid}, 64'd1);
      check("c2_error",  {63'd0, fbus.fetch_error}, 64'd0);
      check("c2_instr",  fbus.fetch_instr, W0_DATA);
      load_we = 1'b0;
      fetch_req(1'b1, 32'h0000_0004);

      // count 3: misaligned fault; fetch out-of-range pc
      @(negedge clk);
      check("c3_valid",    {63'd0, fbus.fetch_valid}, 64'd1);
      check("c3_error",    {63'd0, fbus.fetch_error}, 64'd1);
      check("c3_instr",    fbus.fetch_instr, 64'd0);
      check("c3_progress", {63'd0, progress}, 64'd0);
      fetch_req(1'b1, 32'h0008_0000);
      pc0 = 32'h8000_0100;
      pc1 = 32'h8000_0104;

      // count 4: out-of-range fault, progress pulse
      @(negedge clk);
      check("c4_count",    cycle_count, 64'd4);
      check("c4_progress", {63'd0, progress}, 64'd1);
      check("c4_valid",    {63'd0, fbus.fetch_valid}, 64'd1);
      check("c4_error",    {63'd0, fbus.fetch_error}, 64'd1);
      check("c4_instr",    fbus.fetch_instr, 64'd0);
      fetch_req(1'b0, 32'h0);

      // count 5: idle response, snapshot of count 4; preload word 3 with same-cycle fetch
      @(negedge clk);
      check("c5_valid",    {63'd0, fbus.fetch_valid}, 64'd0);
      check("c5_progress", {63'd0, progress}, 64'd0);
      check("c5_snap_cyc", progress_cycle, 64'd4);
      check("c5_snap_pc0", {32'd0, progress_pc0}, 64'h8000_0100);
      check("c5_snap_pc1", {32'd0, progress_pc1}, 64'h8000_0104);
      load_we = 1'b1; load_addr = 14'd3; load_data = W3_NEW;
      fetch_req(1'b1, 32'h0000_0018);
      pc0 = 32'h8000_0200;

      // count 6: read-before-write returns old word; refetch
      @(negedge clk);
      check("c6_instr",    fbus.fetch_instr, W3_OLD);
      check("c6_error",    {63'd0, fbus.fetch_error}, 64'd0);
      check("c6_snap_pc0", {32'd0, progress_pc0}, 64'h8000_0100);
      load_we = 1'b0;

      // count 7: new word visible
      @(negedge clk);
      check("c7_count", cycle_count, 64'd7);
      check("c7_instr", fbus.fetch_instr, W3_NEW);
      check("c7_valid", {63'd0, fbus.fetch_valid}, 64'd1);
      fetch_req(1'b1, 32'h0000_0000);

      // count 8: third pulse
      @(negedge clk);
      check("c8_count",    cycle_count, 64'd8);
      check("c8_progress", {63'd0, progress}, 64'd1);
      check("c8_instr",    fbus.fetch_instr, W0_DATA);

      // count 9: snapshot of count 8, then async reset with a response in flight
      @(negedge clk);
      check("c9_snap_cyc", progress_cycle, 64'd8);
      check("c9_snap_pc0", {32'd0, progress_pc0}, 64'h8000_0200);
      check("c9_valid",    {63'd0, fbus.fetch_valid}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid",    {63'd0, fbus.fetch_valid}, 64'd0);
      check("mid_rst_count",    cycle_count, 64'd0);
      check("mid_rst_progress", {63'd0, progress}, 64'd1);
      check("mid_rst_snap",     progress_cycle, 64'd0);
      check("mid_rst_snap_pc0", {32'd0, progress_pc0}, 64'd0);

      fetch_req(1'b0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_count",    cycle_count, 64'd1);
      check("rel_progress", {63'd0, progress}, 64'd0);
      check("rel_valid",    {63'd0, fbus.fetch_valid}, 64'd0);
      // ROM survives reset
      fetch_req(1'b1, 32'h0000_0018);
      @(negedge clk);
      check("rel_instr", fbus.fetch_instr, W3_NEW);
      fetch_req(1'b0, 32'h0);
      repeat (2) @(negedge clk);
      check("rel_count4",    cycle_count, 64'd4);
      check("rel_progress4", {63'd0, progress}, 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
